// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two issue lanes, with a registered response slot per lane.
// Optional per-lane stall counters are enabled by defining ALU_ARB_STALL_CNT_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [5:0]       req_funct0,
  input  logic [5:0]       req_funct1,
  input  logic [1:0]       req_aluop0,
  input  logic [1:0]       req_aluop1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data0,
  output logic [WIDTH-1:0] resp_data1,
  output logic [1:0]       resp_zero,
  output logic [1:0]       resp_illegal
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt0,
  output logic [CNT_W-1:0] stall_cnt1
`endif
);

  localparam logic [2:0] SEL_ADD = 3'b010;

  // Returns {illegal, sel}; unknown encodings fall back to add and flag illegal.
  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] d;
    case (op)
      2'b00: d = {1'b0, SEL_ADD};
      2'b01: d = {1'b0, 3'b110};
      2'b11: d = {1'b1, SEL_ADD};
      default: begin
        case (funct)
          6'b100000: d = {1'b0, 3'b010};
          6'b100001: d = {1'b0, 3'b100};
          6'b100010: d = {1'b0, 3'b110};
          6'b100011: d = {1'b0, 3'b110};
          6'b100100: d = {1'b0, 3'b000};
          6'b100101: d = {1'b0, 3'b001};
          6'b000000: d = {1'b0, 3'b101};
          6'b101010: d = {1'b0, 3'b011};
          6'b101011: d = {1'b0, 3'b111};
          default:   d = {1'b1, SEL_ADD};
        endcase
      end
    endcase
    return d;
  endfunction

  logic [WIDTH-1:0] lane_a [2];
  logic [WIDTH-1:0] lane_b [2];
  logic [3:0]       lane_dec [2];
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             prio_reg;

  logic [WIDTH-1:0] data_reg [2];
  logic             valid_reg [2];
  logic             zero_reg [2];
  logic             illegal_reg [2];

  assign lane_a[0]   = req_a0;
  assign lane_a[1]   = req_a1;
  assign lane_b[0]   = req_b0;
  assign lane_b[1]   = req_b1;
  assign lane_dec[0] = decode(req_aluop0, req_funct0);
  assign lane_dec[1] = decode(req_aluop1, req_funct1);

  // A lane may issue only when its response slot is empty or being drained this cycle.
  assign elig = req_valid & (~resp_valid | resp_ready);

  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = prio_reg ? 2'b10 : 2'b01;
  end

  assign req_ready = grant;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_ADD;
    if (grant[0]) begin
      alu_a   = lane_a[0];
      alu_b   = lane_b[0];
      alu_sel = lane_dec[0][2:0];
    end else if (grant[1]) begin
      alu_a   = lane_a[1];
      alu_b   = lane_b[1];
      alu_sel = lane_dec[1][2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_reg <= 1'b0;
    else if (|grant) prio_reg <= ~prio_reg;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi]   <= 1'b0;
          data_reg[gi]    <= '0;
          zero_reg[gi]    <= 1'b0;
          illegal_reg[gi] <= 1'b0;
        end else if (grant[gi]) begin
          valid_reg[gi]   <= 1'b1;
          data_reg[gi]    <= alu_result;
          zero_reg[gi]    <= alu_zero;
          illegal_reg[gi] <= lane_dec[gi][3];
        end else if (resp_ready[gi]) begin
          valid_reg[gi]   <= 1'b0;
        end
      end
    end
  endgenerate

  assign resp_valid   = {valid_reg[1], valid_reg[0]};
  assign resp_zero    = {zero_reg[1], zero_reg[0]};
  assign resp_illegal = {illegal_reg[1], illegal_reg[0]};
  assign resp_data0   = data_reg[0];
  assign resp_data1   = data_reg[1];

`ifdef ALU_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_reg [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stall
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reg[gi] <= '0;
        else if (req_valid[gi] && !grant[gi] && !(&cnt_reg[gi])) cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign stall_cnt0 = cnt_reg[0];
  assign stall_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-level model; bench supplies the ALU.
// Stall counter checks are compiled in when ALU_ARB_STALL_CNT_EN is defined.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [5:0]       req_funct0 = '0, req_funct1 = '0;
  logic [1:0]       req_aluop0 = '0, req_aluop1 = '0;
  logic [WIDTH-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_sel;
  logic             alu_zero;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready = '0;
  logic [WIDTH-1:0] resp_data0, resp_data1;
  logic [1:0]       resp_zero, resp_illegal;
`ifdef ALU_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt0, stall_cnt1;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
`ifdef ALU_ARB_STALL_CNT_EN
    .stall_cnt0(stall_cnt0),
    .stall_cnt1(stall_cnt1),
`endif
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct0(req_funct0), .req_funct1(req_funct1),
    .req_aluop0(req_aluop0), .req_aluop1(req_aluop1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data0(resp_data0), .resp_data1(resp_data1),
    .resp_zero(resp_zero), .resp_illegal(resp_illegal)
  );

  // Bench-side ALU: every select code gives a distinct operation.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, b, input logic [2:0] sel);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return {31'd0, $signed(a) < $signed(b)};
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return a - b;
      default: return {31'd0, a < b};
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_sel);
    alu_zero   = (alu_result == '0);
  end

  int tests = 0;
  int fails = 0;

  logic [5:0] f_tab [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h2a, 6'h2b};
  logic [2:0] s_tab [9] = '{3'd2, 3'd4, 3'd6, 3'd6, 3'd0, 3'd1, 3'd5, 3'd3, 3'd7};

  logic [1:0]       m_valid, m_zero, m_ill;
  logic [WIDTH-1:0] m_data [2];
  logic             m_prio;
  int               m_stall [2];

  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return {1'b0, 3'b010};
    if (op == 2'b01) return {1'b0, 3'b110};
    if (op == 2'b11) return {1'b1, 3'b010};
    for (int i = 0; i < 9; i++) if (f_tab[i] == f) return {1'b0, s_tab[i]};
    return {1'b1, 3'b010};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0; m_zero = '0; m_ill = '0;
    m_data[0] = '0; m_data[1] = '0;
    m_prio = 1'b0;
    m_stall[0] = 0; m_stall[1] = 0;
  endtask

  task automatic check_regs();
    check("resp_valid", resp_valid, m_valid);
    check("resp_data0", resp_data0, m_data[0]);
    check("resp_data1", resp_data1, m_data[1]);
    check("resp_zero", resp_zero, m_zero);
    check("resp_illegal", resp_illegal, m_ill);
`ifdef ALU_ARB_STALL_CNT_EN
    check("stall_cnt0", stall_cnt0, (m_stall[0] > 65535) ? 65535 : m_stall[0]);
    check("stall_cnt1", stall_cnt1, (m_stall[1] > 65535) ? 65535 : m_stall[1]);
`endif
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] rr,
                      input logic [5:0] f0, input logic [5:0] f1,
                      input logic [1:0] o0, input logic [1:0] o1,
                      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    logic [1:0] elig, gnt;
    logic [3:0] d [2];
    logic [WIDTH-1:0] ea, eb, res;
    logic [2:0] es;
    @(negedge clk);
    req_valid = v; resp_ready = rr;
    req_funct0 = f0; req_funct1 = f1; req_aluop0 = o0; req_aluop1 = o1;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    #1;
    d[0] = ref_decode(o0, f0);
    d[1] = ref_decode(o1, f1);
    elig = v & (~m_valid | rr);
    gnt = (elig == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : elig;
    ea = '0; eb = '0; es = 3'b010;
    if (gnt[0]) begin ea = a0; eb = b0; es = d[0][2:0]; end
    else if (gnt[1]) begin ea = a1; eb = b1; es = d[1][2:0]; end
    check("req_ready", req_ready, gnt);
    check("alu_sel", alu_sel, es);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    $display("[TB] t=%0t valid=%b rr=%b grant=%b sel=%b", $time, v, rr, req_ready, alu_sel);
    res = alu_fn(ea, eb, es);
    for (int i = 0; i < 2; i++) begin
      if (v[i] && !gnt[i]) m_stall[i]++;
      if (gnt[i]) begin
        m_valid[i] = 1'b1; m_data[i] = res; m_zero[i] = (res == '0); m_ill[i] = d[i][3];
      end else if (rr[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (|gnt) m_prio = ~m_prio;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    model_reset();
    check("rst_async_valid", resp_valid, 2'b00);
    check_regs();
    check("rst_req_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] op0, op1;
    logic [5:0] fn0, fn1;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    rst_n = 1'b1;

    // Lane 0 add 5 + 7
    step(2'b01, 2'b11, 6'b100000, 6'd0, 2'b10, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0);
    check("t1_data0", resp_data0, 32'd12);
    check("t1_valid", resp_valid, 2'b01);

    // Alternation from reset
    do_reset();
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b11, 6'h22, 6'h25, 2'b10, 2'b10, $urandom, $urandom, $urandom, $urandom);

    // Lane 1 branch compare, equal operands
    step(2'b10, 2'b11, 6'd0, 6'd0, 2'b00, 2'b01, 32'd0, 32'd0, 32'd9, 32'd9);
    check("t3_zero1", resp_zero[1], 1'b1);
    check("t3_data1", resp_data1, 32'd0);

    // Back-pressure on lane 0
    step(2'b01, 2'b00, 6'h20, 6'd0, 2'b10, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b10, 6'h20, 6'h24, 2'b10, 2'b10, $urandom, $urandom, $urandom, $urandom);
    check("t4_hold0", resp_data0, 32'd7);

    // Illegal decodes
    step(2'b01, 2'b11, 6'b111111, 6'd0, 2'b10, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
    check("t5_ill_funct", resp_illegal[0], 1'b1);
    step(2'b01, 2'b11, 6'h20, 6'd0, 2'b11, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
    check("t5_ill_op", resp_illegal[0], 1'b1);

    // Fill both slots, then reset mid-operation
    step(2'b11, 2'b11, 6'h21, 6'h2a, 2'b10, 2'b10, 32'd10, 32'd20, 32'd30, 32'd40);
    step(2'b11, 2'b00, 6'h21, 6'h2a, 2'b10, 2'b10, 32'd10, 32'd20, 32'd30, 32'd40);
    check("t6_full", resp_valid, 2'b11);
    do_reset();
    step(2'b11, 2'b11, 6'h2b, 6'h00, 2'b10, 2'b10, 32'd1, 32'd2, 32'd3, 32'd4);

    for (int n = 0; n < 400; n++) begin
      op0 = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom);
      op1 = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom);
      fn0 = ($urandom_range(0, 9) < 8) ? f_tab[$urandom_range(0, 8)] : 6'($urandom);
      fn1 = ($urandom_range(0, 9) < 8) ? f_tab[$urandom_range(0, 8)] : 6'($urandom);
      step(2'($urandom), 2'($urandom), fn0, fn1, op0, op1,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one execute-stage ALU between the two issue lanes (lane 0, lane 1) of the superscalar pipeline.
- Arbitrates requests round-robin and decodes funct/alu_op into the 3-bit ALU select.
- Drives the shared ALU combinationally and registers each lane's result into a per-lane response register with a valid/ready handshake.
- Sits between the issue/ID-EX stage and the single ALU instance.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of the optional stall counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-lane request valid; bit i = lane i.
- req_ready  output  2  per-lane request accept.
- req_funct0, req_funct1  input  6  R-type funct field per lane.
- req_aluop0, req_aluop1  input  2  main-control alu_op per lane.
- req_a0, req_b0, req_a1, req_b1  input  WIDTH  operands per lane.
- alu_a, alu_b  output  WIDTH  operands to the shared ALU.
- alu_sel  output  3  select to the shared ALU.
- alu_result  input  WIDTH  shared ALU result, combinational from alu_a/alu_b/alu_sel.
- alu_zero  input  1  shared ALU zero flag.
- resp_valid  output  2  per-lane response valid.
- resp_ready  input  2  per-lane response accept.
- resp_data0, resp_data1  output  WIDTH  registered result per lane.
- resp_zero  output  2  registered zero flag per lane.
- resp_illegal  output  2  registered illegal-decode flag per lane.

Behaviour:
- Decode, alu_op -> sel:
  - 00 -> 010 (add).
  - 01 -> 110 (sub, branch).
  - 11 -> 010, with the illegal flag set.
  - 10 -> by funct: 100000->010, 100001->100, 100010->110, 100011->110, 100100->000, 100101->001, 000000->101, 101010->011, 101011->111.
  - Any other funct under alu_op 10 -> 010, with the illegal flag set.
- Eligibility: lane i is eligible when req_valid[i] is high and (resp_valid[i] is low or resp_ready[i] is high). One outstanding result per lane; same-cycle consume-and-refill is allowed.
- Grant:
  - Exactly one eligible lane -> that lane is granted.
  - Both eligible -> the lane with round-robin priority is granted.
  - Priority pointer resets to lane 0 and moves to the other lane after every grant. A single-lane grant also flips it.
- req_ready[i] = grant[i]; combinational, at most one bit set.
- ALU drive:
  - With a grant: alu_a/alu_b/alu_sel come from the granted lane.
  - No grant: alu_a = 0, alu_b = 0, alu_sel = 010.
- Capture:
  - On the edge where req_valid[i] and req_ready[i] are both high, load resp_data_i = alu_result, resp_zero[i] = alu_zero, resp_illegal[i] = decode flag, and set resp_valid[i] = 1.
  - Latency is 1 cycle from accept to resp_valid.
- Response hold:
  - resp_valid[i] clears on an edge with resp_ready[i] high and no new capture for lane i.
  - Data holds stable while resp_valid[i] = 1 and resp_ready[i] = 0.
  - Simultaneous consume + capture: resp_valid stays 1 and new data loads.
- Loser lane: its req_ready stays 0; the requester holds its inputs (no internal request buffering).
- Reset values (async, rst_n low): resp_valid = 00, resp_data0/1 = 0, resp_zero = 00, resp_illegal = 00, priority = lane 0.
- Reset mid-operation drops pending responses with no output glitch beyond reset values.
- Combinational outputs during reset: req_ready follows eligibility with resp_valid = 0, so both gate on req_valid only.
- State: priority flop plus two response registers. No FSM beyond per-lane EMPTY/FULL, encoded by resp_valid[i]:
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on consume without capture.
  - FULL -> FULL on consume with capture, or on hold.

Optional Feature:
- ALU_ARB_STALL_CNT_EN.
- Defined: adds outputs stall_cnt0 and stall_cnt1 (CNT_W each).
  - stall_cnt_i increments on every cycle where req_valid[i] = 1 and req_ready[i] = 0.
  - Counters saturate at all-ones and reset to 0 on rst_n.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Lane 0 only: aluop0 = 10, funct0 = 100000, a0 = 5, b0 = 7 -> alu_sel = 010 and req_ready = 01 that cycle; next cycle resp_valid = 01, resp_data0 = 12, resp_zero[0] = 0.
2. Both lanes valid for 4 cycles from reset, resp_ready = 11 -> grants alternate 01, 10, 01, 10; results are returned on the matching lanes.
3. Lane 1: aluop1 = 01, a1 = b1 = 9 -> alu_sel = 110; resp_zero[1] = 1, resp_data1 = 0.
4. Back-pressure: lane 0 response pending with resp_ready[0] = 0 and req_valid = 11 -> lane 1 granted every cycle; resp_data0 holds; the lane 0 stall counter increments each cycle when the macro is defined.
5. Illegal decode: aluop0 = 10, funct0 = 111111 -> alu_sel = 010 and resp_illegal[0] = 1. Also aluop0 = 11 -> resp_illegal[0] = 1.
6. Assert rst_n = 0 with resp_valid = 11 -> resp_valid = 00 immediately (async). After release with req_valid = 11, lane 0 is granted first.
